// File: rtl/dcache_types_pkg.sv
// Shared types for the 2-way L1 data cache: address split, frame layout, controller states.
package dcache_types_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned DTAG_W = 26;
    localparam int unsigned DIDX_W = 3;
    localparam int unsigned DBYT_W = 2;
    localparam int unsigned LINK_W = 30;

    typedef struct packed {
        logic [DTAG_W-1:0] tag;
        logic [DIDX_W-1:0] idx;
        logic              blkoff;
        logic [DBYT_W-1:0] bytoff;
    } dcachef_t;

    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [DTAG_W-1:0]      tag;
        logic [1:0][WORD_W-1:0] data;
    } dcache_frame_t;

    typedef enum logic [3:0] {
        IDLE,
        WB0,
        WB1,
        LD0,
        LD1,
        FLUSH,
        FWB0,
        FWB1,
        CNT,
        HALTED
    } dcache_state_t;

endpackage

// File: rtl/dcache_link_reg.sv
// LL/SC link register: one word address plus valid, cleared by writes to the word or eviction of its block.
module dcache_link_reg
    import dcache_types_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic              set,
    input  logic              clear,
    input  logic              evict,
    input  logic [LINK_W-1:0] addr,
    input  logic [LINK_W-2:0] evict_blk,
    output logic              match_c
);

    logic              valid;
    logic [LINK_W-1:0] link_addr;

    // Clearing wins; the block part of the link address is everything but the word offset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid     <= 1'b0;
            link_addr <= '0;
        end else if (clear || (evict && valid && (link_addr[LINK_W-1:1] == evict_blk))) begin
            valid <= 1'b0;
        end else if (set) begin
            valid     <= 1'b1;
            link_addr <= addr;
        end
    end

    assign match_c = valid && (link_addr == addr);

endmodule

// File: rtl/dcache_2way.sv
// 2-way set-associative write-back L1 data cache with LL/SC link and halt-time flush.
// Optional hit counter written out during flush: define DCACHE_HITCOUNT_EN.
module dcache_2way
    import dcache_types_pkg::*;
#(
    parameter int unsigned CPUID          = 0,
    parameter int unsigned SETS           = 8,
    parameter logic [31:0] FLUSH_CNT_ADDR = 32'h3100
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic        datomic,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    input  logic        halt,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload
);

`ifdef DCACHE_HITCOUNT_EN
    localparam dcache_state_t FLUSH_DONE = CNT;
`else
    localparam dcache_state_t FLUSH_DONE = HALTED;
`endif

    dcache_state_t state, next_state;
    dcache_frame_t frames [2][SETS];
    logic [SETS-1:0] lru;
    logic            vway;
    logic [3:0]      fcnt;

    dcachef_t      req;
    dcache_frame_t f0, f1, hframe, cand, vframe, fframe;
    logic hit0, hit1, hit, hway, victim;
    logic rd, wr, req_any, is_ll, is_sc, link_match, sc_fail;

    logic wr_hit, lru_touch, set_victim, fill0, fill1, fclean;
    logic fcnt_inc, fcnt_clr, link_set, link_clr, evict;

`ifdef DCACHE_HITCOUNT_EN
    logic        miss_flag, count_hit;
    logic [31:0] hitcnt;
`endif

    assign req     = dcachef_t'(dmemaddr);
    assign f0      = frames[0][req.idx];
    assign f1      = frames[1][req.idx];
    assign hit0    = f0.valid && (f0.tag == req.tag);
    assign hit1    = f1.valid && (f1.tag == req.tag);
    assign hit     = hit0 || hit1;
    assign hway    = hit1;
    assign hframe  = hway ? f1 : f0;
    // An empty way is always taken before consulting LRU.
    assign victim  = !f0.valid ? 1'b0 : (!f1.valid ? 1'b1 : lru[req.idx]);
    assign cand    = victim ? f1 : f0;
    assign vframe  = frames[vway][req.idx];
    assign fframe  = frames[fcnt[3]][fcnt[2:0]];

    assign rd      = dmemREN;
    assign wr      = dmemWEN && !dmemREN;
    assign req_any = rd || wr;
    assign is_ll   = rd && datomic;
    assign is_sc   = wr && datomic;
    assign sc_fail = is_sc && !link_match;

    dcache_link_reg u_link (
        .CLK       (CLK),
        .nRST      (nRST),
        .set       (link_set),
        .clear     (link_clr),
        .evict     (evict),
        .addr      (dmemaddr[31:2]),
        .evict_blk ({cand.tag, req.idx}),
        .match_c   (link_match)
    );

    // State register and controller bookkeeping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            vway  <= 1'b0;
            fcnt  <= 4'd0;
        end else begin
            state <= next_state;
            if (set_victim) vway <= victim;
            if (fcnt_clr) fcnt <= 4'd0;
            else if (fcnt_inc) fcnt <= fcnt + 4'd1;
        end
    end

    // Frame array and LRU updates.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int w = 0; w < 2; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    frames[w][s] <= '0;
                end
            end
            lru <= '0;
        end else begin
            if (wr_hit) begin
                frames[hway][req.idx].data[req.blkoff] <= dmemstore;
                frames[hway][req.idx].dirty            <= 1'b1;
            end
            if (lru_touch) lru[req.idx] <= ~hway;
            if (fill0) frames[vway][req.idx].data[0] <= dload;
            if (fill1) begin
                frames[vway][req.idx].data[1] <= dload;
                frames[vway][req.idx].valid   <= 1'b1;
                frames[vway][req.idx].dirty   <= 1'b0;
                frames[vway][req.idx].tag     <= req.tag;
            end
            if (fclean) frames[fcnt[3]][fcnt[2:0]].dirty <= 1'b0;
        end
    end

`ifdef DCACHE_HITCOUNT_EN
    // Hits are counted only for requests that did not need a refill first.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            miss_flag <= 1'b0;
            hitcnt    <= 32'd0;
        end else begin
            if (set_victim) miss_flag <= 1'b1;
            else if (dhit) miss_flag <= 1'b0;
            if (count_hit) hitcnt <= hitcnt + 32'd1;
        end
    end
`endif

    always_comb begin
        next_state = state;
        dhit       = 1'b0;
        dmemload   = 32'd0;
        flushed    = 1'b0;
        dREN       = 1'b0;
        dWEN       = 1'b0;
        daddr      = 32'd0;
        dstore     = 32'd0;
        wr_hit     = 1'b0;
        lru_touch  = 1'b0;
        set_victim = 1'b0;
        fill0      = 1'b0;
        fill1      = 1'b0;
        fclean     = 1'b0;
        fcnt_inc   = 1'b0;
        fcnt_clr   = 1'b0;
        link_set   = 1'b0;
        link_clr   = 1'b0;
        evict      = 1'b0;
`ifdef DCACHE_HITCOUNT_EN
        count_hit  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sc_fail) begin
                    dhit     = 1'b1;
                    link_clr = 1'b1;
                end else if (req_any && hit) begin
                    dhit      = 1'b1;
                    lru_touch = 1'b1;
                    dmemload  = is_sc ? 32'd1 : hframe.data[req.blkoff];
                    wr_hit    = wr;
                    link_set  = is_ll;
                    link_clr  = wr && link_match;
`ifdef DCACHE_HITCOUNT_EN
                    count_hit = !miss_flag;
`endif
                end else if (req_any) begin
                    set_victim = 1'b1;
                    evict      = cand.valid;
                    next_state = (cand.valid && cand.dirty) ? WB0 : LD0;
                end else if (halt) begin
                    fcnt_clr   = 1'b1;
                    next_state = FLUSH;
                end
            end
            WB0: begin
                dWEN   = 1'b1;
                daddr  = {vframe.tag, req.idx, 1'b0, 2'b00};
                dstore = vframe.data[0];
                if (!dwait) next_state = WB1;
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = {vframe.tag, req.idx, 1'b1, 2'b00};
                dstore = vframe.data[1];
                if (!dwait) next_state = LD0;
            end
            LD0: begin
                dREN  = 1'b1;
                daddr = {req.tag, req.idx, 1'b0, 2'b00};
                if (!dwait) begin
                    fill0      = 1'b1;
                    next_state = LD1;
                end
            end
            LD1: begin
                dREN  = 1'b1;
                daddr = {req.tag, req.idx, 1'b1, 2'b00};
                if (!dwait) begin
                    fill1      = 1'b1;
                    next_state = IDLE;
                end
            end
            FLUSH: begin
                if (fframe.valid && fframe.dirty) next_state = FWB0;
                else if (fcnt == 4'hF) next_state = FLUSH_DONE;
                else fcnt_inc = 1'b1;
            end
            FWB0: begin
                dWEN   = 1'b1;
                daddr  = {fframe.tag, fcnt[2:0], 1'b0, 2'b00};
                dstore = fframe.data[0];
                if (!dwait) next_state = FWB1;
            end
            FWB1: begin
                dWEN   = 1'b1;
                daddr  = {fframe.tag, fcnt[2:0], 1'b1, 2'b00};
                dstore = fframe.data[1];
                if (!dwait) begin
                    fclean = 1'b1;
                    if (fcnt == 4'hF) begin
                        next_state = FLUSH_DONE;
                    end else begin
                        fcnt_inc   = 1'b1;
                        next_state = FLUSH;
                    end
                end
            end
`ifdef DCACHE_HITCOUNT_EN
            CNT: begin
                dWEN   = 1'b1;
                daddr  = FLUSH_CNT_ADDR;
                dstore = hitcnt;
                if (!dwait) next_state = HALTED;
            end
`endif
            HALTED: begin
                flushed = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    logic unused_ok;
    assign unused_ok = ^{1'(CPUID), req.bytoff, FLUSH_CNT_ADDR};

endmodule

// File: doc/dcache_2way.md
Name: dcache_2way

Overview:
- L1 data cache between the pipelined datapath's MEM stage and the memory/cache-control arbiter.
- Organisation: 2-way set-associative, write-back, write-allocate; 8 sets × 2 ways × 2-word blocks (128 B).
- Serves LW/SW/LL/SC from the datapath through a single link register.
- On halt, writes back all dirty blocks, then raises `flushed`.

Parameters:
- `CPUID`, 0, core id; reserved for coherence, unused by logic.
- `SETS`, 8, number of sets; fixed index width 3.
- `FLUSH_CNT_ADDR`, 32'h3100, address the optional hit counter is written to.

Ports:
- `CLK` in 1 clock
- `nRST` in 1 reset, asynchronous, active-low
- `dmemREN` in 1 datapath read request (LW/LL)
- `dmemWEN` in 1 datapath write request (SW/SC)
- `datomic` in 1 request is LL (with REN) or SC (with WEN)
- `dmemaddr` in 32 word address; byte offset ignored
- `dmemstore` in 32 store data
- `halt` in 1 datapath halted; start flush
- `dhit` out 1 request completed this cycle
- `dmemload` out 32 load data; SC result (1 success / 0 fail)
- `flushed` out 1 flush complete; sticky until reset
- `dREN` out 1 memory read request
- `dWEN` out 1 memory write request
- `daddr` out 32 memory address
- `dstore` out 32 memory write data
- `dwait` in 1 memory busy; a transfer completes on the cycle `dwait` is low
- `dload` in 32 memory read data, valid when `dwait` is low

Behaviour:
- Address split: tag[31:6] (26 bits), idx[5:3], blkoff[2], byteoff[1:0].
- Frame contents: valid, dirty, tag, data[2]. Per-set state: one LRU bit naming the victim way.
- Reset:
  - All valid, dirty and LRU bits cleared; link register invalid; hit counter 0; state IDLE.
  - Outputs: `dhit`=0, `dmemload`=0, `flushed`=0, `dREN`=0, `dWEN`=0, `daddr`=0, `dstore`=0.
  - Reset mid-transfer aborts immediately; memory side is deasserted the same cycle.
- IDLE hit (combinational, same cycle):
  - `dhit`=1; `dmemload` = data of the matching way.
  - Writes update data on the next edge and set dirty.
  - LRU bit set to the other way.
  - REN and WEN together is illegal; REN takes priority.
- IDLE miss:
  - Victim = way named by LRU; the invalid way is preferred if one exists.
  - Victim dirty → WB0; otherwise → LD0.
- WB0 / WB1:
  - `dWEN`=1, `daddr`={victim tag, idx, blkoff, 2'b00}, `dstore`=word[blkoff].
  - Advance on `dwait`=0; WB1 → LD0.
- LD0 / LD1:
  - `dREN`=1, `daddr`={req tag, idx, blkoff, 2'b00}; latch `dload` on `dwait`=0.
  - After LD1: frame valid=1, dirty=0, tag written; return to IDLE, where the request then hits.
- `dhit` is never asserted outside IDLE. Requests must stay stable until `dhit`; the datapath stalls meanwhile.
- LL (REN & `datomic`): on hit, link register ← {addr[31:2], valid=1}; `dmemload` = data.
- SC (WEN & `datomic`):
  - Link valid and link addr == addr[31:2]:
    - Behaves as SW (including miss handling).
    - `dmemload`=1 with `dhit`; link cleared.
  - Otherwise: no cache or memory access; `dhit`=1 immediately; `dmemload`=0; link cleared.
- Any SW/SC write hit to the linked word clears the link. An eviction of the linked block also clears it.
- Flush (`halt`=1 sampled in IDLE with no pending request):
  - FLUSH walks frames 0..15 (way-major, then idx); one counter, 4 bits.
  - Dirty frame: write word0 then word1 (same handshake as WB). Clean/invalid frame: skip in 1 cycle.
  - After frame 15 → [CNT] → HALTED.
  - HALTED: `flushed`=1, all memory requests 0, stays until reset.
  - `halt` arriving during a miss is honoured only after returning to IDLE.

Optional Feature:
- Macro: `DCACHE_HITCOUNT_EN`.
- Defined:
  - 32-bit hit counter increments on each IDLE `dhit` for a request that did not miss (tracked by a miss flag set on leaving IDLE, cleared on `dhit`). Failed SC does not count.
  - Flush inserts state CNT: `dWEN`=1, `daddr`=`FLUSH_CNT_ADDR`, `dstore`=count, until `dwait`=0.
- Undefined: no counter, no CNT state; flush goes frame 15 → HALTED.

Decomposition:
- Package `dcache_types_pkg`:
  - `dcachef_t` address struct (tag/idx/blkoff/bytoff).
  - `dcache_frame_t` (valid, dirty, tag, data[2]).
  - `dcache_state_t` enum (IDLE, WB0, WB1, LD0, LD1, FLUSH, FWB0, FWB1, CNT, HALTED).
  - Constants `DTAG_W`=26, `DIDX_W`=3.
- Sub-module `dcache_link_reg`: link valid/address register with set/clear/match logic; everything else stays in one module.

Test Plan:
- Cold LW 0x0040, `dload`=0xAAAA0001/0xAAAA0002 (`dwait` low after 2 cycles each) → `dREN` at 0x40 then 0x44; `dhit` in IDLE with `dmemload`=0xAAAA0001. Repeat LW 0x0044 → same-cycle `dhit`, 0xAAAA0002, no `dREN`.
- SW 0x0040 ← 0x12345678, then LW 0x0440 and LW 0x0840 (same idx 0) → second miss evicts way of 0x0040: WB writes 0x12345678 to 0x40 and 0xAAAA0002 to 0x44 before `dREN` 0x840.
- LL 0x0080 then SC 0x0080 ← 5 → `dmemload`=1, later LW 0x80 returns 5. LL 0x80, SW 0x80 ← 7, SC 0x80 ← 9 → `dmemload`=0, LW returns 7, no memory traffic for the SC.
- Dirty blocks in idx 1 way0 and idx 5 way1, assert `halt` → exactly 4 `dWEN` transfers in frame order, then `flushed`=1. With `DCACHE_HITCOUNT_EN` and 3 prior hits: a final write of 3 to 0x3100.
- Assert `nRST` low during LD0 → `dREN`=0 immediately; after release, LW to a previously loaded address misses.
